comp_popcnt_sched: RTL and testbench
====================================

Name: comp_popcnt_sched

Overview:
- Round-robin scheduler that shares one Comp_single256 popcount compressor (256-bit column in, 9-bit count out, fixed pipeline depth) among NUM_REQ requesters.
- Requesters submit packets of one or more 256-bit beats; the block serialises beats into the compressor one per cycle and tags each beat through the pipeline.
- It accumulates the per-beat counts at the compressor output and returns one total per packet, with the requester id.
- It sits between the bit-column producers and the downstream comparison/threshold logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- COMP_LAT, 3, clock cycles from a Comp_single256 in_col0 change to the matching comp_out; must equal the instance's pipeline depth.
- SUM_W, 16, width of the packet sum and the beat counter (≥ 9).
- ID_W, $clog2(NUM_REQ), derived localparam, requester id width.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept; at most one bit high.
- req_data  in  NUM_REQ*256  beat data; requester i occupies bits [i*256 +: 256].
- req_last  in  NUM_REQ  marks the final beat of a packet.
- res_valid  out  1  one-cycle pulse: packet result valid. No backpressure.
- res_id  out  ID_W  requester index of the result.
- res_sum  out  SUM_W  total set bits over all beats of the packet.
- res_beats  out  SUM_W  number of beats in the packet.
- res_sat  out  1  res_sum or res_beats saturated.

Behaviour:
- Reset values: res_valid, res_id, res_sum, res_beats, res_sat, req_ready = 0. The tag pipeline valid bits, accumulators, RR pointer (=0) and FSM (IDLE) are all cleared.
- Handshake: a beat is accepted when req_valid[i] && req_ready[i]. req_ready may depend combinationally on req_valid; req_valid must not depend on req_ready.
- FSM IDLE:
  - Winner = first requester with valid, searching from rr_ptr upward with wrap. Its ready is 1.
  - Accepted beat without last -> BURST, locked to the winner.
  - Accepted beat with last (single-beat packet) -> stay IDLE, rr_ptr = winner+1 mod NUM_REQ.
- FSM BURST:
  - req_ready = locked requester only, regardless of other valids.
  - Valid gaps create bubbles; the lock is held.
  - Accepted last beat -> IDLE, rr_ptr = locked+1.
- Issue stage: the accepted beat is registered into an issue register feeding in_col0 (cycle T+1). A tag {valid, id, last} is registered alongside.
  - On a bubble, issue data holds its value and tag.valid = 0.
- Tag pipeline: COMP_LAT-deep shift register aligned with the comp_out of the issued beat.
- Accumulation: occurs at tag output with tag.valid = 1.
  - Add zero-extended comp_out to acc_sum and increment acc_beats.
  - Saturate both at 2^SUM_W-1 and set the sticky sat flag.
- On tag.last, register res_* from the updated totals, pulse res_valid for one cycle, and clear acc/sat the same cycle.
  - The next packet's first beat may accumulate in the very next cycle.
- Latency: last-beat acceptance at cycle T -> res_valid at T+COMP_LAT+2. Throughput is one beat per cycle. Back-to-back single-beat packets give res_valid on consecutive cycles.
- Packets from different requesters never interleave, so one accumulator suffices. Results emerge in acceptance order.
- Reset mid-operation clears tags, FSM and accumulators. In-flight beats are discarded and no res_valid is produced. Comp_single256 has no reset; its output is ignored because the tags are invalid.
- A requester that drops valid forever mid-packet stalls all others. This is a protocol violation and is not recovered.

Decomposition:
- Package comp_sched_pkg: tag struct typedef (valid, id, last), COMP_W = 256, CNT_W = 9, the rr_next function.
- Instantiates Comp_single256 directly.
- One natural sub-module, comp_rr_arb: round-robin pick with lock input and grant-one-hot/index outputs.
- The tag pipeline and accumulator stay in the top module.

Test Plan:
- req0 sends one beat, all-ones, last=1 at cycle T -> res_valid at T+5 (COMP_LAT=3), res_id=0, res_sum=256, res_beats=1, res_sat=0.
- req1 sends 3 beats {all-ones, 0, 256'h1}, last on the third -> single result: res_id=1, res_sum=257, res_beats=3.
- All four requesters hold valid with continuous single-beat packets of 256'hF -> grants cycle 0,1,2,3,0…; results arrive every cycle with ids 0,1,2,3, sum=4.
- req2 starts a 4-beat packet and drops valid for 2 cycles after beat 2 while req0 is valid -> req0_ready stays 0 until req2's last beat is accepted. The result is res_beats=4, and req3 is granted next if valid, else req0.
- req0 sends 256 all-ones beats -> res_sum=65535, res_beats=256, res_sat=1; the following packet reports res_sat=0.
- Assert rst_n=0 for 1 cycle while 2 beats are in flight -> no res_valid follows. A fresh packet after reset returns the correct sum with rr_ptr at 0.

Source files
------------

// File: rtl/comp_sched_pkg.sv
// Shared types and helpers for the popcount compressor scheduler.
package comp_sched_pkg;

    localparam int COMP_W   = 256;
    localparam int CNT_W    = 9;
    localparam int MAX_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic                last;
    } tag_t;

    typedef enum logic {
        IDLE,
        BURST
    } sched_state_e;

    function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/Comp_single256.sv
// 256-bit column popcount, three register stages, no reset.
module Comp_single256
    import comp_sched_pkg::*;
(
    input  logic              clk,
    input  logic [COMP_W-1:0] in_col0,
    output logic [CNT_W-1:0]  comp_out
);

    logic [6:0] s1_q [4];
    logic [7:0] s2_q [2];
    logic [8:0] s3_q;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            s1_q[i] <= 7'($countones(in_col0[i*64 +: 64]));
        end
        s2_q[0] <= {1'b0, s1_q[0]} + {1'b0, s1_q[1]};
        s2_q[1] <= {1'b0, s1_q[2]} + {1'b0, s1_q[3]};
        s3_q    <= {1'b0, s2_q[0]} + {1'b0, s2_q[1]};
    end

    assign comp_out = s3_q;

endmodule

// File: rtl/comp_rr_arb.sv
// Round-robin requester pick from a pointer, with an override lock.
module comp_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               lock_i,
    input  logic [ID_W-1:0]    lock_id_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_any_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        cand      = '0;
        if (lock_i) begin
            // Locked grant ignores valid so a mid-packet gap keeps others out.
            gnt_idx_o = lock_id_i;
            gnt_any_o = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((32'(ptr_i) + k) % NUM_REQ);
                if (!gnt_any_o && valid_i[cand]) begin
                    gnt_idx_o = cand;
                    gnt_any_o = 1'b1;
                end
            end
        end
        gnt_o[gnt_idx_o] = gnt_any_o;
    end

endmodule

// File: rtl/comp_popcnt_sched.sv
// Shares one Comp_single256 among requesters; returns per-packet popcount totals.
module comp_popcnt_sched
    import comp_sched_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  COMP_LAT = 3,
    parameter int  SUM_W    = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*COMP_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [SUM_W-1:0]          res_sum,
    output logic [SUM_W-1:0]          res_beats,
    output logic                      res_sat
);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              accept;

    logic [COMP_W-1:0] issue_data_q, issue_data_d;
    tag_t              issue_tag_q, issue_tag_d;
    tag_t              tag_pipe_q [COMP_LAT];
    tag_t              tag_out;
    logic [CNT_W-1:0]  comp_out;

    logic [SUM_W-1:0]  acc_sum_q, acc_sum_d, acc_beats_q, acc_beats_d;
    logic              acc_sat_q, acc_sat_d;
    logic [SUM_W:0]    sum_ext, beats_ext;
    logic [SUM_W-1:0]  sum_upd, beats_upd;
    logic              sat_upd;

    logic              res_valid_q, res_valid_d, res_sat_q, res_sat_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [SUM_W-1:0]  res_sum_q, res_sum_d, res_beats_q, res_beats_d;
    logic              unused_tag_id;

    comp_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid_i   (req_valid),
        .ptr_i     (rr_ptr_q),
        .lock_i    (state_q == BURST),
        .lock_id_i (lock_id_q),
        .gnt_o     (req_ready),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    Comp_single256 u_comp (
        .clk      (clk),
        .in_col0  (issue_data_q),
        .comp_out (comp_out)
    );

    assign accept = gnt_any && req_valid[gnt_idx];

    always_comb begin
        state_d      = state_q;
        lock_id_d    = lock_id_q;
        rr_ptr_d     = rr_ptr_q;
        issue_data_d = issue_data_q;
        issue_tag_d  = '0;
        if (accept) begin
            issue_data_d      = req_data[gnt_idx*COMP_W +: COMP_W];
            issue_tag_d.valid = 1'b1;
            issue_tag_d.id    = MAX_ID_W'(gnt_idx);
            issue_tag_d.last  = req_last[gnt_idx];
            if (req_last[gnt_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = ID_W'(rr_next(32'(gnt_idx), NUM_REQ));
            end else begin
                state_d   = BURST;
                lock_id_d = gnt_idx;
            end
        end
    end

    assign tag_out       = tag_pipe_q[COMP_LAT-1];
    assign unused_tag_id = ^tag_out.id;

    always_comb begin
        sum_ext   = {1'b0, acc_sum_q} + (SUM_W+1)'(comp_out);
        beats_ext = {1'b0, acc_beats_q} + (SUM_W+1)'(1);
        sum_upd   = sum_ext[SUM_W]   ? '1 : sum_ext[SUM_W-1:0];
        beats_upd = beats_ext[SUM_W] ? '1 : beats_ext[SUM_W-1:0];
        sat_upd   = acc_sat_q | sum_ext[SUM_W] | beats_ext[SUM_W];

        acc_sum_d   = acc_sum_q;
        acc_beats_d = acc_beats_q;
        acc_sat_d   = acc_sat_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_sum_d   = res_sum_q;
        res_beats_d = res_beats_q;
        res_sat_d   = res_sat_q;
        if (tag_out.valid) begin
            if (tag_out.last) begin
                // Publish the updated totals and restart so the next packet's
                // first beat can land in the very next cycle.
                res_valid_d = 1'b1;
                res_id_d    = tag_out.id[ID_W-1:0];
                res_sum_d   = sum_upd;
                res_beats_d = beats_upd;
                res_sat_d   = sat_upd;
                acc_sum_d   = '0;
                acc_beats_d = '0;
                acc_sat_d   = 1'b0;
            end else begin
                acc_sum_d   = sum_upd;
                acc_beats_d = beats_upd;
                acc_sat_d   = sat_upd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lock_id_q    <= '0;
            rr_ptr_q     <= '0;
            issue_data_q <= '0;
            issue_tag_q  <= '0;
            for (int unsigned i = 0; i < COMP_LAT; i++) tag_pipe_q[i] <= '0;
            acc_sum_q    <= '0;
            acc_beats_q  <= '0;
            acc_sat_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_sum_q    <= '0;
            res_beats_q  <= '0;
            res_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_id_q    <= lock_id_d;
            rr_ptr_q     <= rr_ptr_d;
            issue_data_q <= issue_data_d;
            issue_tag_q  <= issue_tag_d;
            tag_pipe_q[0] <= issue_tag_q;
            for (int unsigned i = 1; i < COMP_LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
            acc_sum_q    <= acc_sum_d;
            acc_beats_q  <= acc_beats_d;
            acc_sat_q    <= acc_sat_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_sum_q    <= res_sum_d;
            res_beats_q  <= res_beats_d;
            res_sat_q    <= res_sat_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_beats = res_beats_q;
    assign res_sat   = res_sat_q;

endmodule

// File: tb/tb_comp_popcnt_sched.sv
// Directed bench for comp_popcnt_sched: single-beat table plus multi-cycle sequences.
module tb_comp_popcnt_sched;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*256-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic            res_valid;
    logic [1:0]      res_id;
    logic [15:0]     res_sum;
    logic [15:0]     res_beats;
    logic            res_sat;

    comp_popcnt_sched #(
        .NUM_REQ  (NR),
        .COMP_LAT (3),
        .SUM_W    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_beats (res_beats),
        .res_sat   (res_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int id;
        int sum;
        int beats;
        int sat;
    } res_t;

    typedef struct {
        int           req;
        logic [255:0] data;
        int           exp_sum;
    } vec_t;

    res_t res_q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && res_valid)
            res_q.push_back('{cyc, int'(res_id), int'(res_sum), int'(res_beats), int'(res_sat)});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, wanted $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_q.delete();
    endtask

    // Drives one beat at posedge+1, returns at posedge+1 after acceptance.
    task automatic beat(input int r, input logic [255:0] d, input logic l, output int t_acc);
        int n;
        n = 0;
        req_valid[r] = 1'b1;
        req_data[r*256 +: 256] = d;
        req_last[r] = l;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 200);
        t_acc = cyc;
        if (!req_ready[r]) begin
            tot_cnt++;
            $display("FAIL accept_timeout: req %0d never got ready", r);
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
        req_last[r] = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (res_q.size() < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("result_count", res_q.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input int i, input int id, input int sum, input int beats, input int sat);
        if (res_q.size() <= i) begin
            tot_cnt++;
            $display("FAIL result_missing: got %0d results, wanted index %0d", res_q.size(), i);
        end else begin
            chk("res_id", res_q[i].id, id);
            chk("res_sum", res_q[i].sum, sum);
            chk("res_beats", res_q[i].beats, beats);
            chk("res_sat", res_q[i].sat, sat);
        end
    endtask

    initial begin
        vec_t vecs[5];
        int t, t0;
        logic [255:0] d;

        vecs[0] = '{0, {256{1'b1}}, 256};
        vecs[1] = '{3, 256'h0, 0};
        vecs[2] = '{2, 256'h1, 1};
        vecs[3] = '{1, {64{4'hA}}, 128};
        vecs[4] = '{2, {32{8'h81}}, 64};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_beats", res_beats, 0);
        chk("rst_res_sat", res_sat, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;

        // Single-beat packets with latency T+5
        for (int i = 0; i < 5; i++) begin
            res_q.delete();
            beat(vecs[i].req, vecs[i].data, 1'b1, t);
            wait_results(1);
            check_res(0, vecs[i].req, vecs[i].exp_sum, 1, 0);
            if (res_q.size() > 0) chk("latency", res_q[0].cyc - t, 5);
        end

        // Three-beat packet from req1
        res_q.delete();
        d = 256'h1;
        beat(1, {256{1'b1}}, 1'b0, t);
        beat(1, 256'h0, 1'b0, t);
        beat(1, d, 1'b1, t);
        wait_results(1);
        check_res(0, 1, 257, 3, 0);

        // All requesters streaming single-beat packets
        do_reset();
        req_valid = '1;
        req_last = '1;
        for (int r = 0; r < NR; r++) req_data[r*256 +: 256] = 256'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, longint'(1) << (i % 4));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        req_last = '0;
        wait_results(8);
        for (int i = 0; i < 8 && i < res_q.size(); i++) begin
            chk("rr_res_id", res_q[i].id, i % 4);
            chk("rr_res_sum", res_q[i].sum, 4);
            chk("rr_res_cycle", res_q[i].cyc - res_q[0].cyc, i);
        end

        // Locked burst with a valid gap while others wait
        do_reset();
        req_valid[2] = 1'b1;
        req_data[2*256 +: 256] = 256'h1;
        @(negedge clk);
        chk("lock_first", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        req_data[2*256 +: 256] = 256'h3;
        req_valid[0] = 1'b1;
        req_last[0] = 1'b1;
        req_data[0 +: 256] = 256'h3F;
        req_valid[3] = 1'b1;
        req_last[3] = 1'b1;
        req_data[3*256 +: 256] = 256'h1F;
        @(negedge clk);
        chk("lock_beat2", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lock_gap", req_ready, 4'b0100);
            @(posedge clk);
            #1;
        end
        req_valid[2] = 1'b1;
        req_data[2*256 +: 256] = 256'h7;
        @(negedge clk);
        chk("lock_beat3", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        req_data[2*256 +: 256] = 256'hF;
        req_last[2] = 1'b1;
        @(negedge clk);
        chk("lock_beat4", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        req_last[2] = 1'b0;
        @(negedge clk);
        chk("after_lock_req3", req_ready, 4'b1000);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        @(negedge clk);
        chk("after_req3_req0", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_results(3);
        check_res(0, 2, 10, 4, 0);
        check_res(1, 3, 5, 1, 0);
        check_res(2, 0, 6, 1, 0);

        // Saturation over 256 all-ones beats, then a clean packet
        do_reset();
        for (int i = 0; i < 255; i++) beat(0, {256{1'b1}}, 1'b0, t);
        beat(0, {256{1'b1}}, 1'b1, t);
        wait_results(1);
        check_res(0, 0, 65535, 256, 1);
        res_q.delete();
        beat(0, 256'hFF, 1'b1, t);
        wait_results(1);
        check_res(0, 0, 8, 1, 0);

        // Reset with two beats in flight
        do_reset();
        beat(0, {256{1'b1}}, 1'b0, t0);
        beat(0, {256{1'b1}}, 1'b1, t);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_inflight_no_result", res_q.size(), 0);
        @(posedge clk);
        #1;
        req_valid = '1;
        req_last = '1;
        for (int r = 0; r < NR; r++) req_data[r*256 +: 256] = 256'h7;
        @(negedge clk);
        chk("rst_rr_ptr0", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        req_last = '0;
        wait_results(1);
        check_res(0, 0, 3, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
